// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single Wishbone-style memory bus.
// One transfer in flight at a time. Ties alternate between the two requesters,
// with data winning the first tie after reset. A stalled slave is abandoned
// after TIMEOUT strobe cycles and the transfer is reported back with bus_err.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_address,
  output logic [31:0] instruction,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_address,
  input  logic [31:0] mem_store,
  output logic [31:0] memload,
  output logic        d_ack,
  output logic        bus_err,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack
);

  // A zero TIMEOUT still gets a 1-bit counter; it is simply never compared.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The abort fires on the edge that ends the TIMEOUT-th unacknowledged strobe cycle.
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : CW'(0);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, IBUS, DBUS, RESP} state_t;
  typedef enum logic {GRANT_INSTR, GRANT_DATA} grant_t;

  state_t        state_reg, state_next;
  grant_t        last_grant_reg, last_grant_next;
  logic          stb_reg, stb_next;
  logic          we_reg, we_next;
  logic [3:0]    sel_reg, sel_next;
  logic [31:0]   adr_reg, adr_next;
  logic [31:0]   dat_o_reg, dat_o_next;
  logic [31:0]   instr_reg, instr_next;
  logic [31:0]   memload_reg, memload_next;
  logic          err_reg, err_next;
  logic          i_ack_reg, i_ack_next;
  logic          d_ack_reg, d_ack_next;
  logic [CW-1:0] count_reg, count_next;
  logic          timeout_hit;
  logic          grant_data;

  assign timeout_hit = (TIMEOUT > 0) && (count_reg == TO_LAST);
  // Data wins when it is alone or when fetch was the last side served.
  assign grant_data  = d_req && (!i_req || (last_grant_reg == GRANT_INSTR));

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    stb_next        = stb_reg;
    we_next         = we_reg;
    sel_next        = sel_reg;
    adr_next        = adr_reg;
    dat_o_next      = dat_o_reg;
    instr_next      = instr_reg;
    memload_next    = memload_reg;
    err_next        = err_reg;
    i_ack_next      = 1'b0;
    d_ack_next      = 1'b0;
    count_next      = count_reg;

    unique case (state_reg)
      IDLE: begin
        if (grant_data) begin
          adr_next        = d_address;
          we_next         = d_we;
          sel_next        = d_sel;
          dat_o_next      = d_we ? mem_store : 32'h0;
          stb_next        = 1'b1;
          count_next      = '0;
          last_grant_next = GRANT_DATA;
          state_next      = DBUS;
        end else if (i_req) begin
          adr_next        = i_address;
          we_next         = 1'b0;
          sel_next        = 4'hF;
          dat_o_next      = 32'h0;
          stb_next        = 1'b1;
          count_next      = '0;
          last_grant_next = GRANT_INSTR;
          state_next      = IBUS;
        end
      end
      IBUS, DBUS: begin
        if (bus_ack) begin
          stb_next   = 1'b0;
          err_next   = 1'b0;
          state_next = RESP;
          if (state_reg == IBUS) begin
            instr_next = bus_dat_i;
            i_ack_next = 1'b1;
          end else begin
            memload_next = we_reg ? 32'h0 : bus_dat_i;
            d_ack_next   = 1'b1;
          end
        end else if (timeout_hit) begin
          stb_next   = 1'b0;
          err_next   = 1'b1;
          state_next = RESP;
          if (state_reg == IBUS) begin
            instr_next = 32'h0;
            i_ack_next = 1'b1;
          end else begin
            memload_next = 32'h0;
            d_ack_next   = 1'b1;
          end
        end else if (count_reg != CNT_MAX) begin
          count_next = count_reg + CW'(1);
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_INSTR;
      stb_reg        <= 1'b0;
      we_reg         <= 1'b0;
      sel_reg        <= 4'h0;
      adr_reg        <= 32'h0;
      dat_o_reg      <= 32'h0;
      instr_reg      <= 32'h0;
      memload_reg    <= 32'h0;
      err_reg        <= 1'b0;
      i_ack_reg      <= 1'b0;
      d_ack_reg      <= 1'b0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      stb_reg        <= stb_next;
      we_reg         <= we_next;
      sel_reg        <= sel_next;
      adr_reg        <= adr_next;
      dat_o_reg      <= dat_o_next;
      instr_reg      <= instr_next;
      memload_reg    <= memload_next;
      err_reg        <= err_next;
      i_ack_reg      <= i_ack_next;
      d_ack_reg      <= d_ack_next;
      count_reg      <= count_next;
    end
  end

  assign bus_cyc     = stb_reg;
  assign bus_stb     = stb_reg;
  assign bus_we      = we_reg;
  assign bus_sel     = sel_reg;
  assign bus_adr     = adr_reg;
  assign bus_dat_o   = dat_o_reg;
  assign instruction = instr_reg;
  assign memload     = memload_reg;
  assign bus_err     = err_reg;
  assign i_ack       = i_ack_reg;
  assign d_ack       = d_ack_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, store with wait states, tie
// alternation, address stability, timeout abort and reset mid-transfer.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_address;
  logic [31:0] instruction;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_address;
  logic [31:0] mem_store;
  logic [31:0] memload;
  logic        d_ack;
  logic        bus_err;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_adr;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack;

  int checks = 0;
  int failures = 0;

  mem_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_address(i_address), .instruction(instruction), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_address(d_address),
    .mem_store(mem_store), .memload(memload), .d_ack(d_ack), .bus_err(bus_err),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_adr(bus_adr), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_address = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_sel = 4'h0; d_address = 32'h0; mem_store = 32'h0; bus_dat_i = 32'h0; bus_ack = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_cyc", 32'(bus_cyc), 32'h0);
    chk("rst_stb", 32'(bus_stb), 32'h0);
    chk("rst_iack", 32'(i_ack), 32'h0);
    chk("rst_dack", 32'(d_ack), 32'h0);
    chk("rst_adr", bus_adr, 32'h0);
    rst = 1'b0;
    tick();

    // 1. Fetch with zero-wait slave
    i_req = 1'b1; i_address = 32'h100;
    $display("txn fetch addr=0x100");
    tick();
    chk("f_stb", 32'(bus_stb), 32'h1);
    chk("f_cyc", 32'(bus_cyc), 32'h1);
    chk("f_adr", bus_adr, 32'h100);
    chk("f_sel", 32'(bus_sel), 32'hF);
    chk("f_we", 32'(bus_we), 32'h0);
    chk("f_dato", bus_dat_o, 32'h0);
    chk("f_iack_early", 32'(i_ack), 32'h0);
    bus_ack = 1'b1; bus_dat_i = 32'h00A00093;
    tick();
    chk("f_iack", 32'(i_ack), 32'h1);
    chk("f_instr", instruction, 32'h00A00093);
    chk("f_stb_off", 32'(bus_stb), 32'h0);
    chk("f_dack", 32'(d_ack), 32'h0);
    chk("f_err", 32'(bus_err), 32'h0);
    i_req = 1'b0; bus_ack = 1'b0; bus_dat_i = 32'hDEADBEEF;
    tick();
    chk("f_iack_pulse", 32'(i_ack), 32'h0);

    // 2+4. Store with two wait states; address changes mid-transfer
    d_req = 1'b1; d_we = 1'b1; d_sel = 4'hF; d_address = 32'h40; mem_store = 32'd30;
    $display("txn store addr=0x40 data=30");
    tick();
    chk("s_stb1", 32'(bus_stb), 32'h1);
    chk("s_we", 32'(bus_we), 32'h1);
    chk("s_dato1", bus_dat_o, 32'd30);
    d_address = 32'h80;
    tick();
    chk("s_stb2", 32'(bus_stb), 32'h1);
    chk("s_dato2", bus_dat_o, 32'd30);
    chk("s_adr_hold2", bus_adr, 32'h40);
    tick();
    chk("s_stb3", 32'(bus_stb), 32'h1);
    chk("s_dato3", bus_dat_o, 32'd30);
    chk("s_adr_hold3", bus_adr, 32'h40);
    chk("s_dack_early", 32'(d_ack), 32'h0);
    bus_ack = 1'b1;
    tick();
    chk("s_dack", 32'(d_ack), 32'h1);
    chk("s_memload", memload, 32'h0);
    chk("s_err", 32'(bus_err), 32'h0);
    chk("s_stb_off", 32'(bus_stb), 32'h0);
    d_req = 1'b0; d_we = 1'b0; bus_ack = 1'b0;
    tick();
    chk("s_dack_pulse", 32'(d_ack), 32'h0);

    // 3. Both requests from reset: D,I,D,I with zero-wait slave
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_req = 1'b1; i_address = 32'h200; d_req = 1'b1; d_address = 32'h300; d_sel = 4'h3;
    bus_ack = 1'b1; bus_dat_i = 32'h12345678;
    $display("txn tie i=0x200 d=0x300");
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("t_dack_c%0d", c), 32'(d_ack), (c % 6 == 2) ? 32'h1 : 32'h0);
      chk($sformatf("t_iack_c%0d", c), 32'(i_ack), (c % 6 == 5) ? 32'h1 : 32'h0);
      if (c % 6 == 1) chk($sformatf("t_adr_c%0d", c), bus_adr, 32'h300);
      if (c % 6 == 4) chk($sformatf("t_adr_c%0d", c), bus_adr, 32'h200);
      if (c % 6 == 2) chk($sformatf("t_memload_c%0d", c), memload, 32'h12345678);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0; bus_ack = 1'b0;
    tick();

    // 5. Timeout after 4 strobe cycles on a load
    d_req = 1'b1; d_we = 1'b0; d_address = 32'h500; d_sel = 4'hF;
    $display("txn load timeout addr=0x500");
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("to_stb_c%0d", c), 32'(bus_stb), 32'h1);
      chk($sformatf("to_dack_c%0d", c), 32'(d_ack), 32'h0);
      tick();
    end
    chk("to_stb_off", 32'(bus_stb), 32'h0);
    chk("to_dack", 32'(d_ack), 32'h1);
    chk("to_err", 32'(bus_err), 32'h1);
    chk("to_memload", memload, 32'h0);
    d_req = 1'b0;
    tick();
    chk("to_dack_pulse", 32'(d_ack), 32'h0);

    // 6. Reset mid-transfer, then normal fetch
    i_req = 1'b1; i_address = 32'h600;
    $display("txn fetch with reset abort addr=0x600");
    tick();
    chk("r_stb_before", 32'(bus_stb), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("r_stb_async", 32'(bus_stb), 32'h0);
    chk("r_cyc_async", 32'(bus_cyc), 32'h0);
    chk("r_iack_async", 32'(i_ack), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("r2_stb", 32'(bus_stb), 32'h1);
    chk("r2_adr", bus_adr, 32'h600);
    bus_ack = 1'b1; bus_dat_i = 32'hCAFEF00D;
    tick();
    chk("r2_iack", 32'(i_ack), 32'h1);
    chk("r2_instr", instruction, 32'hCAFEF00D);
    chk("r2_err", 32'(bus_err), 32'h0);
    i_req = 1'b0; bus_ack = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time bound reached");
  end

endmodule
